// File: rtl/port_bus_master.sv
// port_bus_master: KCPSM6-style I/O port bus initiator for host read/write commands plus interrupt service (sensor read, ack pulse, count)
module port_bus_master #(
  parameter int READ_LATENCY = 1,
  parameter logic [7:0] ISR_PORT = 8'h0D,
  parameter bit ISR_ENABLE = 1'b1
) (
  input  logic        sysclk,
  input  logic        sysreset,
  output logic [7:0]  port_id,
  output logic        write_strobe,
  output logic        read_strobe,
  output logic [7:0]  out_port,
  input  logic [7:0]  in_port,
  input  logic        interrupt,
  output logic        interrupt_ack,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_port,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [7:0]  isr_sensor,
  output logic [15:0] isr_count,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, ISR_ISSUE, ISR_WAIT, ISR_ACK} state_t;
  state_t state;
  logic [1:0] cnt;
  assign busy = state != IDLE;
  assign cmd_ready = state == IDLE && !(ISR_ENABLE && interrupt) && !sysreset;
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state <= IDLE;
      cnt <= '0;
      port_id <= '0;
      out_port <= '0;
      write_strobe <= 1'b0;
      read_strobe <= 1'b0;
      interrupt_ack <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      isr_sensor <= '0;
      isr_count <= '0;
    end else begin
      write_strobe <= 1'b0;
      read_strobe <= 1'b0;
      interrupt_ack <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ISR_ENABLE && interrupt) begin
            state <= ISR_ISSUE;
            port_id <= ISR_PORT;
            read_strobe <= 1'b1;
          end else if (cmd_valid) begin
            state <= cmd_write ? WR : RD_ISSUE;
            port_id <= cmd_port;
            out_port <= cmd_write ? cmd_wdata : out_port;
            write_strobe <= cmd_write;
            read_strobe <= !cmd_write;
          end
        end
        WR: state <= IDLE;
        RD_ISSUE: begin
          state <= RD_WAIT;
          cnt <= 2'(READ_LATENCY - 1);
        end
        RD_WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd0) begin
            state <= IDLE;
            rsp_rdata <= in_port;
            rsp_valid <= 1'b1;
          end
        end
        ISR_ISSUE: begin
          state <= ISR_WAIT;
          cnt <= 2'(READ_LATENCY - 1);
        end
        ISR_WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd0) begin
            state <= ISR_ACK;
            isr_sensor <= in_port;
            interrupt_ack <= 1'b1;
          end
        end
        ISR_ACK: begin
          state <= IDLE;
          isr_count <= isr_count + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_port_bus_master.sv
// tb_port_bus_master: directed vector bench for port_bus_master with registered-read interface models
module tb_port_bus_master;
  logic sysclk = 1'b0;
  logic sysreset = 1'b1;
  always #5 sysclk = ~sysclk;
  logic cmd_valid = 1'b1, cmd_valid3 = 1'b1, cmd_write = 1'b1, irq_req = 1'b0;
  logic [7:0] cmd_port = 8'h02, cmd_wdata = 8'hA5;
  logic interrupt = 1'b0;
  logic [7:0] port_id, out_port, in_port, rsp_rdata, isr_sensor;
  logic write_strobe, read_strobe, interrupt_ack, cmd_ready, rsp_valid, busy;
  logic [15:0] isr_count;
  logic [7:0] port_id3, out_port3, in_port3, rsp_rdata3, isr_sensor3;
  logic write_strobe3, read_strobe3, interrupt_ack3, cmd_ready3, rsp_valid3, busy3;
  logic [15:0] isr_count3;
  logic [7:0] rd1 = 8'hEE, d1 = 8'hEE, d2 = 8'hEE, d3 = 8'hEE;
  logic ack3_seen = 1'b0;
  int checks = 0, fails = 0, exp_cnt = 0;
  port_bus_master dut (
    .sysclk(sysclk), .sysreset(sysreset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_port(cmd_port), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .isr_sensor(isr_sensor), .isr_count(isr_count), .busy(busy)
  );
  port_bus_master #(.READ_LATENCY(3), .ISR_ENABLE(1'b0)) dut3 (
    .sysclk(sysclk), .sysreset(sysreset), .port_id(port_id3), .write_strobe(write_strobe3),
    .read_strobe(read_strobe3), .out_port(out_port3), .in_port(in_port3), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack3), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_write(cmd_write), .cmd_port(cmd_port), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid3),
    .rsp_rdata(rsp_rdata3), .isr_sensor(isr_sensor3), .isr_count(isr_count3), .busy(busy3)
  );
  function automatic logic [7:0] rom(input logic [7:0] p);
    return p == 8'h0D ? 8'h07 : p ^ 8'h36;
  endfunction
  assign in_port = rd1;
  assign in_port3 = d3;
  always @(posedge sysclk) begin
    rd1 <= read_strobe ? rom(port_id) : 8'hEE;
    d1 <= read_strobe3 ? rom(port_id3) : 8'hEE;
    d2 <= d1;
    d3 <= d2;
    interrupt <= interrupt_ack ? 1'b0 : (interrupt | irq_req);
  end
  always @(negedge sysclk) if (interrupt_ack3 || write_strobe3) ack3_seen <= 1'b1;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct {logic wr; logic [7:0] port; logic [7:0] wdata; logic [7:0] rdata;} vec_t;
  task automatic run_vec(input vec_t x);
    cmd_write = x.wr; cmd_port = x.port; cmd_wdata = x.wdata; cmd_valid = 1'b1;
    chk("ready_e0", 16'(cmd_ready), 16'd1);
    @(negedge sysclk); cmd_valid = 1'b0;
    chk("ready_e1", 16'(cmd_ready), 16'd0);
    chk("wstb_e1", 16'(write_strobe), 16'(x.wr));
    chk("rstb_e1", 16'(read_strobe), 16'(!x.wr));
    chk("port_e1", 16'(port_id), 16'(x.port));
    if (x.wr) chk("out_e1", 16'(out_port), 16'(x.wdata));
    @(negedge sysclk);
    chk("wstb_e2", 16'(write_strobe), 16'd0);
    chk("rstb_e2", 16'(read_strobe), 16'd0);
    chk("rsp_e2", 16'(rsp_valid), 16'd0);
    chk("ready_e2", 16'(cmd_ready), 16'(x.wr));
    if (!x.wr) begin
      chk("port_e2", 16'(port_id), 16'(x.port));
      @(negedge sysclk);
      chk("rsp_e3", 16'(rsp_valid), 16'd1);
      chk("rdata_e3", 16'(rsp_rdata), 16'(x.rdata));
      chk("busy_e3", 16'(busy), 16'd0);
    end
  endtask
  task automatic wait_ack();
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (interrupt_ack) return;
    end
    chk("ack_timeout", 16'd0, 16'd1);
  endtask
  vec_t v[6];
  initial begin
    int n, first_i, second_i;
    v[0] = '{1'b1, 8'h02, 8'hA5, 8'h00};
    v[1] = '{1'b0, 8'h0A, 8'h00, 8'h3C};
    v[2] = '{1'b1, 8'hFF, 8'h00, 8'h00};
    v[3] = '{1'b0, 8'h00, 8'h00, 8'h36};
    v[4] = '{1'b0, 8'hFF, 8'h00, 8'hC9};
    v[5] = '{1'b1, 8'h0D, 8'h5A, 8'h00};
    repeat (2) begin
      @(negedge sysclk);
      chk("rst_ready", 16'(cmd_ready), 16'd0);
      chk("rst_wstb", 16'({write_strobe, read_strobe, interrupt_ack, rsp_valid, busy}), 16'd0);
      chk("rst_port", 16'(port_id), 16'd0);
      chk("rst_out", 16'(out_port), 16'd0);
      chk("rst_rdata", 16'(rsp_rdata), 16'd0);
      chk("rst_sensor", 16'(isr_sensor), 16'd0);
      chk("rst_count", isr_count, 16'd0);
    end
    sysreset = 1'b0; cmd_valid = 1'b0; cmd_valid3 = 1'b0;
    @(negedge sysclk);
    chk("post_rst_ready", 16'(cmd_ready), 16'd1);
    chk("post_rst_ready3", 16'(cmd_ready3), 16'd1);
    chk("post_rst_wstb", 16'(write_strobe), 16'd0);
    for (int i = 0; i < 6; i++) run_vec(v[i]);
    @(negedge sysclk);
    cmd_write = 1'b0; cmd_port = 8'h0A; cmd_valid3 = 1'b1;
    @(negedge sysclk); cmd_valid3 = 1'b0;
    chk("l3_rstb_e1", 16'(read_strobe3), 16'd1);
    chk("l3_port_e1", 16'(port_id3), 16'h0A);
    for (int i = 2; i <= 4; i++) begin
      @(negedge sysclk);
      chk("l3_rsp_wait", 16'(rsp_valid3), 16'd0);
      chk("l3_rstb_wait", 16'(read_strobe3), 16'd0);
      chk("l3_busy_wait", 16'(busy3), 16'd1);
      chk("l3_port_wait", 16'(port_id3), 16'h0A);
    end
    @(negedge sysclk);
    chk("l3_rsp_e5", 16'(rsp_valid3), 16'd1);
    chk("l3_rdata_e5", 16'(rsp_rdata3), 16'h3C);
    @(negedge sysclk);
    chk("l3_rsp_e6", 16'(rsp_valid3), 16'd0);
    irq_req = 1'b1;
    @(negedge sysclk);
    irq_req = 1'b0; cmd_write = 1'b0; cmd_port = 8'h0B; cmd_valid = 1'b1;
    chk("pri_ready", 16'(cmd_ready), 16'd0);
    @(negedge sysclk);
    chk("pri_isr_rstb", 16'(read_strobe), 16'd1);
    chk("pri_isr_port", 16'(port_id), 16'h0D);
    @(negedge sysclk);
    chk("pri_isr_wait_port", 16'(port_id), 16'h0D);
    chk("pri_isr_wait_ack", 16'(interrupt_ack), 16'd0);
    @(negedge sysclk);
    chk("pri_ack", 16'(interrupt_ack), 16'd1);
    chk("pri_sensor", 16'(isr_sensor), 16'h07);
    chk("pri_rsp_untouched", 16'(rsp_rdata), 16'hC9);
    chk("pri_ack_ready", 16'(cmd_ready), 16'd0);
    exp_cnt++;
    @(negedge sysclk);
    chk("pri_ack_done", 16'(interrupt_ack), 16'd0);
    chk("pri_count", isr_count, 16'(exp_cnt));
    chk("pri_ready_after", 16'(cmd_ready), 16'd1);
    @(negedge sysclk); cmd_valid = 1'b0;
    chk("pri_cmd_rstb", 16'(read_strobe), 16'd1);
    chk("pri_cmd_port", 16'(port_id), 16'h0B);
    repeat (2) @(negedge sysclk);
    chk("pri_cmd_rsp", 16'(rsp_valid), 16'd1);
    chk("pri_cmd_rdata", 16'(rsp_rdata), 16'h3D);
    cmd_port = 8'h0A; cmd_valid = 1'b1;
    @(negedge sysclk); cmd_valid = 1'b0; irq_req = 1'b1;
    @(negedge sysclk);
    chk("mid_ready", 16'(cmd_ready), 16'd0);
    @(negedge sysclk);
    chk("mid_rsp", 16'(rsp_valid), 16'd1);
    chk("mid_rdata", 16'(rsp_rdata), 16'h3C);
    n = 0; first_i = -1; second_i = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge sysclk);
      if (interrupt_ack) begin
        n++;
        if (n == 1) first_i = i;
        if (n == 2) begin second_i = i; irq_req = 1'b0; end
      end
    end
    exp_cnt += 2;
    chk("mid_ack_count", 16'(n), 16'd2);
    chk("mid_first_ack", 16'(first_i), 16'd2);
    chk("mid_second_ack", 16'(second_i), 16'd7);
    chk("mid_isr_count", isr_count, 16'(exp_cnt));
    cmd_port = 8'h0A; cmd_valid = 1'b1;
    @(negedge sysclk); cmd_valid = 1'b0;
    @(negedge sysclk); sysreset = 1'b1;
    @(negedge sysclk); sysreset = 1'b0;
    chk("abort_rsp", 16'(rsp_valid), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_port", 16'(port_id), 16'd0);
    chk("abort_rdata", 16'(rsp_rdata), 16'd0);
    chk("abort_count", isr_count, 16'd0);
    exp_cnt = 0;
    @(negedge sysclk);
    chk("abort_rsp_late", 16'(rsp_valid), 16'd0);
    chk("abort_ready", 16'(cmd_ready), 16'd1);
    irq_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_ack();
      chk("en0_ready", 16'(cmd_ready3), 16'd1);
      exp_cnt++;
      @(negedge sysclk);
      chk("loop_count", isr_count, 16'(exp_cnt));
    end
    irq_req = 1'b0;
    repeat (3) @(negedge sysclk);
    force dut.isr_count = 16'hFFFF;
    @(negedge sysclk);
    release dut.isr_count;
    @(negedge sysclk);
    chk("wrap_preset", isr_count, 16'hFFFF);
    irq_req = 1'b1;
    wait_ack();
    @(negedge sysclk);
    chk("wrap_zero", isr_count, 16'h0000);
    wait_ack();
    irq_req = 1'b0;
    @(negedge sysclk);
    chk("wrap_one", isr_count, 16'h0001);
    repeat (4) @(negedge sysclk);
    chk("wrap_stable", isr_count, 16'h0001);
    chk("en0_no_ack", 16'(ack3_seen), 16'd0);
    chk("en0_count", isr_count3, 16'd0);
    chk("en0_sensor", 16'(isr_sensor3), 16'd0);
    chk("en0_out", 16'(out_port3), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/port_bus_master.md
Name: port_bus_master

Overview:
- Hardware initiator for the KCPSM6-style I/O port bus: drives port_id, write_strobe, read_strobe and out_port, and samples in_port.
- Services the closed-loop interrupt handshake by reading a sensor port and pulsing interrupt_ack.
- Sits in the processor's place in front of a nexys4 I/O interface, so a debug host or hardware autopilot can poke ports without a PicoBlaze.

Parameters:
- READ_LATENCY, 1, cycles between the read_strobe cycle and the cycle in which in_port is valid (legal 1..3). The interface registers its read data, hence 1.
- ISR_PORT, 8'h0D, port read by the interrupt service sequence (sensor register).
- ISR_ENABLE, 1, 1 = service interrupts; 0 = ignore interrupt and never assert interrupt_ack.

Ports:
- sysclk  in  1  system clock
- sysreset  in  1  synchronous reset, active-high
- port_id  out  8  I/O port address
- write_strobe  out  1  write qualifier, one-cycle pulse
- read_strobe  out  1  read qualifier, one-cycle pulse
- out_port  out  8  write data to the interface
- in_port  in  8  read data from the interface
- interrupt  in  1  interrupt request from the interface
- interrupt_ack  out  1  interrupt acknowledge, one-cycle pulse
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command accepted when valid&&ready at a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_port  in  8  target port
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  8  last read data, held until the next read completes
- isr_sensor  out  8  value captured by the last ISR read
- isr_count  out  16  number of ISRs completed, wraps FFFF->0000
- busy  out  1  state != IDLE

Behaviour:
- Single clock sysclk. Reset is synchronous and active-high on sysreset.
- Reset values: state IDLE; port_id, out_port, rsp_rdata, isr_sensor = 0; isr_count = 0; strobes, interrupt_ack, rsp_valid, busy = 0.
- Bus outputs are decoded from the state register and latched command registers only. There is no combinational path from any input to port_id, strobes, out_port or interrupt_ack.
- cmd_ready = (state==IDLE) && !(ISR_ENABLE && interrupt) && !sysreset. This is the only combinational output.
- States: IDLE, WR, RD_ISSUE, RD_WAIT, ISR_ISSUE, ISR_WAIT, ISR_ACK.
- IDLE:
  - If ISR_ENABLE && interrupt -> ISR_ISSUE. Interrupt has priority over a pending command, and no command is accepted that cycle.
  - Else if cmd_valid: latch cmd_port/cmd_wdata, then go to WR if cmd_write, else RD_ISSUE.
- WR (1 cycle): port_id=latched port, out_port=latched data, write_strobe=1 -> IDLE. No rsp_valid for writes.
- RD_ISSUE (1 cycle): port_id=latched port, read_strobe=1 -> RD_WAIT.
- RD_WAIT (READ_LATENCY cycles, internal counter): port_id held, strobes 0.
  - On the last cycle, capture in_port into rsp_rdata -> IDLE.
  - rsp_valid=1 in the following cycle (registered pulse). A new command may be accepted in that same cycle.
- Read timing at READ_LATENCY=1:
  - Accept at edge E.
  - read_strobe high in cycle E+1; port_id held for cycles E+1..E+2.
  - Capture at the end of E+2; rsp_valid in cycle E+3.
- ISR_ISSUE and ISR_WAIT: identical to RD_ISSUE and RD_WAIT with port_id=ISR_PORT; capture goes into isr_sensor. rsp_valid and rsp_rdata are untouched.
- ISR_ACK (1 cycle): interrupt_ack=1, isr_count+1 (mod 2^16) -> IDLE.
  - The interface clears interrupt on the ack edge, so interrupt is low in the following IDLE cycle and there is no double service.
  - A request re-raised later starts a new ISR.
- Interrupt asserted during WR/RD_*: the transaction completes uninterrupted; the ISR starts from the next IDLE cycle.
- Interrupt deasserted before the ISR finishes: the sequence still completes, including the ack pulse.
- Reset mid-transaction: the transaction is aborted. From the cycle after the reset edge all outputs are at reset values, no rsp_valid or ack is emitted, and the latched command is discarded.
- ISR_ENABLE=0: ISR states unreachable, interrupt_ack tied 0, isr_count stays 0.

Test Plan:
- Reset: assert sysreset 2 cycles with cmd_valid=1, interrupt=0 -> all outputs 0, cmd_ready=0 during reset and 1 after, no strobe ever seen.
- Write: cmd write port 0x02 data 0xA5 -> exactly one cycle (E+1) with write_strobe=1, port_id=0x02, out_port=0xA5; cmd_ready=0 in E+1 and 1 in E+2; no rsp_valid.
- Read via interface model (registered read, port 0x0A returns 0x3C), READ_LATENCY=1 -> read_strobe only in E+1, port_id=0x0A in E+1..E+2, rsp_valid in E+3 with rsp_rdata=0x3C. Repeat with READ_LATENCY=3 -> rsp_valid at E+5.
- Interrupt priority: interrupt and cmd_valid (read 0x0B) rise together, port 0x0D returns 0x07.
  - ISR runs first: read of 0x0D, isr_sensor=0x07, a single interrupt_ack pulse, isr_count=1.
  - The command is then accepted and returns the 0x0B data.
- Interrupt mid-read: raise interrupt during RD_WAIT -> read finishes with correct rsp, then exactly one ISR. interrupt_request held high across the ack -> a second ISR follows, isr_count=2.
- Abort and wrap:
  - Assert sysreset during RD_WAIT -> no rsp_valid, busy=0 next cycle.
  - Run 65537 ISRs -> isr_count wraps to 0x0001.
